// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a bi-directional serial shift register: optional clear, LSB-first
// shifting of up to WIDTH bits, then capture of the parallel output behind a valid/ready result.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_dir_i,
  input  logic             cmd_clr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic             abort_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic             busy_o,
  output logic             sh_en_o,
  output logic             sh_clr_o,
  output logic             sh_dir_o,
  output logic             sh_din_o,
  input  logic [WIDTH-1:0] sh_q_i
);

  typedef enum logic [2:0] {StIdle, StClear, StShift, StCapture, StDone} state_e;

  localparam logic [LEN_W-1:0] LenMax = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;

  logic             res_valid_d, busy_d, sh_en_d, sh_clr_d, sh_dir_d, sh_din_d;
  logic [WIDTH-1:0] res_data_d;

  logic [LEN_W-1:0] eff_len;
  logic             last_shift;

  // Zero or oversize lengths shift a full register.
  assign eff_len     = (cmd_len_i == '0 || cmd_len_i > LenMax) ? LenMax : cmd_len_i;
  assign last_shift  = (cnt_q == len_q - LenOne);
  assign cmd_ready_o = (state_q == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (cmd_valid_i) state_d = cmd_clr_i ? StClear : StShift;
      StClear:   state_d = abort_i ? StIdle : StShift;
      StShift:   begin
        if (abort_i)         state_d = StIdle;
        else if (last_shift) state_d = StCapture;
      end
      StCapture: state_d = abort_i ? StIdle : StDone;
      StDone:    if (abort_i || res_ready_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    len_d  = len_q;
    data_d = data_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    if (state_q == StIdle && cmd_valid_i) begin
      len_d  = eff_len;
      data_d = cmd_data_i;
      dir_d  = cmd_dir_i;
      cnt_d  = '0;
    end else if (state_q == StShift && state_d == StShift) begin
      cnt_d = cnt_q + LenOne;
    end
  end

  // Outputs are computed from the next state so they are registered yet aligned with the state.
  always_comb begin
    busy_d      = (state_d != StIdle);
    sh_en_d     = (state_d == StShift);
    sh_clr_d    = (state_d == StClear);
    res_valid_d = (state_d == StDone);
    sh_dir_d    = sh_dir_o;
    sh_din_d    = sh_din_o;
    res_data_d  = res_data_o;
    if (state_d == StShift) begin
      sh_dir_d = dir_d;
      sh_din_d = |(data_d & (WIDTH'(1) << cnt_d));
    end
    if (state_q == StCapture && state_d == StDone) begin
      res_data_d = sh_q_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      dir_q       <= 1'b0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      busy_o      <= 1'b0;
      sh_en_o     <= 1'b0;
      sh_clr_o    <= 1'b0;
      sh_dir_o    <= 1'b0;
      sh_din_o    <= 1'b0;
    end else begin
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      dir_q       <= dir_d;
      res_valid_o <= res_valid_d;
      res_data_o  <= res_data_d;
      busy_o      <= busy_d;
      sh_en_o     <= sh_en_d;
      sh_clr_o    <= sh_clr_d;
      sh_dir_o    <= sh_dir_d;
      sh_din_o    <= sh_din_d;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed cases plus random commands, checked against an
// arithmetic model of the shift register and the command timing.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0, cmd_clr = 1'b0;
  logic [2:0] cmd_len = '0;
  logic [3:0] cmd_data = '0;
  logic       abort = 1'b0, res_valid, res_ready = 1'b0;
  logic [3:0] res_data;
  logic       busy, sh_en, sh_clr, sh_dir, sh_din;
  logic [3:0] sh_q = '0;

  int errors = 0;
  int checks = 0;

  shift_seq_ctrl #(.WIDTH(4), .LEN_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_dir_i   (cmd_dir),
    .cmd_clr_i   (cmd_clr),
    .cmd_len_i   (cmd_len),
    .cmd_data_i  (cmd_data),
    .abort_i     (abort),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .busy_o      (busy),
    .sh_en_o     (sh_en),
    .sh_clr_o    (sh_clr),
    .sh_dir_o    (sh_dir),
    .sh_din_o    (sh_din),
    .sh_q_i      (sh_q)
  );

  always #5 clk = ~clk;

  // The external shift register the controller drives.
  always @(posedge clk) begin
    if (sh_clr)      sh_q <= 4'b0000;
    else if (sh_en)  sh_q <= sh_dir ? {sh_din, sh_q[3:1]} : {sh_q[2:0], sh_din};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register contents after an optional clear and n serial bits, by plain arithmetic.
  function automatic logic [3:0] ref_shift(input logic [3:0] q0, input logic clr, input logic dir,
                                           input int n, input logic [3:0] data);
    int v;
    int b;
    v = clr ? 0 : int'(q0);
    for (int i = 0; i < n; i++) begin
      b = (int'(data) >> i) % 2;
      if (!dir) v = (v * 2 + b) % 16;
      else      v = v / 2 + b * 8;
    end
    return 4'(v);
  endfunction

  function automatic int eff_len(input logic [2:0] len);
    return (len == 0 || len > 4) ? 4 : int'(len);
  endfunction

  // Drive a command at a falling edge; returns at the falling edge after the accept edge.
  task automatic start_cmd(input logic clr, input logic dir, input logic [2:0] len,
                           input logic [3:0] data);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_clr   = clr;
    cmd_dir   = dir;
    cmd_len   = len;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits until n cycles with sh_en high have been seen (including the current one).
  task automatic wait_en(input int n, input string tag);
    int seen;
    seen = 0;
    for (int k = 0; k < 20 && seen < n; k++) begin
      if (k > 0) @(negedge clk);
      if (sh_en) seen++;
    end
    check(tag, seen, n);
  endtask

  // mode 0: finish with res_ready after rdy_delay stall cycles; mode 1: abort in DONE.
  task automatic run_cmd(input logic clr, input logic dir, input logic [2:0] len,
                         input logic [3:0] data, input int rdy_delay, input int mode);
    int         l;
    int         en_cnt;
    int         clr_cnt;
    int         lat;
    logic [3:0] exp_q;
    l       = eff_len(len);
    exp_q   = ref_shift(sh_q, clr, dir, l, data);
    en_cnt  = 0;
    clr_cnt = 0;
    lat     = -1;
    start_cmd(clr, dir, len, data);
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      if (sh_clr) clr_cnt++;
      if (sh_en) begin
        check("sh_din", sh_din, data[en_cnt % 4]);
        check("sh_dir", sh_dir, dir);
        en_cnt++;
      end
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    // Edges counted inclusive of the accept edge.
    check("latency", lat + 1, clr ? l + 3 : l + 2);
    check("en_cycles", en_cnt, l);
    check("clr_cycles", clr_cnt, clr ? 1 : 0);
    check("res_data", res_data, exp_q);
    check("busy_done", busy, 1);
    check("ready_done", cmd_ready, 0);
    for (int c = 0; c < rdy_delay; c++) begin
      @(negedge clk);
      check("stall_valid", res_valid, 1);
      check("stall_data", res_data, exp_q);
      check("stall_ready", cmd_ready, 0);
    end
    if (mode == 1) begin
      abort     = 1'b1;
      res_ready = 1'($urandom_range(1));
    end else begin
      res_ready = 1'b1;
    end
    @(negedge clk);
    abort     = 1'b0;
    res_ready = 1'b0;
    check("hs_valid", res_valid, 0);
    check("hs_ready", cmd_ready, 1);
    check("hs_busy", busy, 0);
  endtask

  initial begin
    logic [3:0] d;
    logic       dir;
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    logic       dir;

    // Reset values
    @(negedge clk);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_en", sh_en, 0);
    check("rst_clr", sh_clr, 0);
    check("rst_dir", sh_dir, 0);
    check("rst_din", sh_din, 0);
    check("rst_ready", cmd_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-shift: after two of four shifts have landed
    start_cmd(1'b1, 1'b0, 3'd4, 4'b1011);
    wait_en(3, "rst_wait_en");
    #2 rst = 1'b1;
    #1;
    check("midrst_en", sh_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", res_valid, 0);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_q", sh_q, ref_shift(4'b0000, 1'b1, 1'b0, 2, 4'b1011));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_cmd(1'b1, 1'b0, 3'd4, 4'b1011, 0, 0);
    check("left_const", res_data, 4'b1101);
    run_cmd(1'b1, 1'b1, 3'd4, 4'b1011, 0, 0);
    check("right_const", res_data, 4'b1011);
    run_cmd(1'b0, 1'b0, 3'd2, 4'b0010, 0, 0);
    check("noclr_const", res_data, 4'b1101);
    run_cmd(1'b1, 1'b0, 3'd0, 4'($urandom), 5, 0);
    run_cmd(1'b0, 1'b1, 3'd7, 4'($urandom), 1, 0);
    run_cmd(1'b1, 1'b1, 3'd1, 4'($urandom), 2, 1);

    // Abort during the third shift
    d   = 4'($urandom);
    dir = 1'($urandom_range(1));
    start_cmd(1'b1, dir, 3'd4, d);
    wait_en(3, "abort_wait_en");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_en", sh_en, 0);
    check("abort_clr", sh_clr, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", res_valid, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_q", sh_q, ref_shift(4'b0000, 1'b1, dir, 3, d));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_res", res_valid, 0);
      check("abort_q_hold", sh_q, ref_shift(4'b0000, 1'b1, dir, 3, d));
    end

    // Abort while idle is ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_ready", cmd_ready, 1);
    check("idle_abort_busy", busy, 0);

    // Random commands
    for (int i = 0; i < 25; i++) begin
      run_cmd(1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)),
              4'($urandom), int'($urandom_range(3)), ($urandom_range(4) == 0) ? 1 : 0);
      repeat (int'($urandom_range(2))) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencer for the team's 4-bit bi-directional serial shift register.
- Accepts a command to (optionally) clear the register, then shift a given number of bits into it in a chosen direction, LSB of the command word first.
- Samples the register's parallel output and returns it to the requester over a valid/ready result handshake.
- Sits between a command master and the shift register. It drives the register's d_in/direction/enable/clear pins and reads back its parallel output.

Parameters:
- WIDTH, 4, register width in bits and maximum shift length.
- LEN_W, 3, width of cmd_len; must be able to represent WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_dir  input  1  0 = shift left, 1 = shift right.
- cmd_clr  input  1  1 = clear register before shifting.
- cmd_len  input  LEN_W  number of bits to shift.
- cmd_data  input  WIDTH  serial bits, bit 0 shifted first.
- abort  input  1  synchronous cancel of the current command.
- res_valid  output  1  result available.
- res_ready  input  1  requester accepts result.
- res_data  output  WIDTH  captured register contents.
- busy  output  1  high in any state other than IDLE.
- sh_en  output  1  register shift enable.
- sh_clr  output  1  register synchronous clear.
- sh_dir  output  1  register direction, same encoding as cmd_dir.
- sh_din  output  1  register serial input.
- sh_q  input  WIDTH  register parallel output.

Behaviour:
- Register contract (for checking):
  - sh_clr=1: q<=0.
  - else sh_en=1, sh_dir=0: q<={q[WIDTH-2:0],sh_din}.
  - else sh_en=1, sh_dir=1: q<={sh_din,q[WIDTH-1:1]}.
  - else q holds.
- States: IDLE, CLEAR, SHIFT, CAPTURE, DONE. All sh_* outputs, res_* outputs and busy are registered. cmd_ready is the combinational decode of state==IDLE.
- Reset (asynchronous, any state):
  - state=IDLE.
  - res_valid=0, res_data=0, busy=0, sh_en=0, sh_clr=0, sh_dir=0, sh_din=0.
  - Bit counter and latched command cleared.
  - cmd_ready=1, because the state is IDLE.
- IDLE:
  - On cmd_valid&&cmd_ready, latch dir, data and effective length.
  - Effective length L = cmd_len. If cmd_len==0 or cmd_len>WIDTH, L=WIDTH.
  - Go to CLEAR if cmd_clr=1, else go to SHIFT.
- CLEAR: exactly one cycle with sh_clr=1 and sh_en=0, then SHIFT.
- SHIFT:
  - Exactly L cycles with sh_en=1, sh_dir=latched dir, and sh_din=latched data[i] for i=0..L-1.
  - Then CAPTURE with sh_en=0.
- CAPTURE: one settle cycle; res_data<=sh_q at its end; then DONE.
- DONE:
  - res_valid=1; res_data stable until res_valid&&res_ready.
  - On the handshake edge, res_valid falls and state returns to IDLE.
  - A new command cannot be accepted in the same cycle as the handshake.
- Latency, counted from the accept edge to the edge on which res_valid rises:
  - L+3 edges with clear.
  - L+2 edges without clear.
- Abort:
  - Valid in CLEAR, SHIFT or CAPTURE: on the next edge go to IDLE; sh_en and sh_clr fall; no result is produced; register keeps partial contents.
  - In DONE: res_valid drops and the result is discarded.
  - In IDLE: ignored.
  - If abort and res_ready arrive together in DONE, abort wins (same outcome).
- Commands arriving while not IDLE are not accepted (cmd_ready=0). The master must hold them.
- The sh_* outputs hold their last values in IDLE except sh_en and sh_clr, which are 0.

Test Plan:
- Reset mid-SHIFT (assert rst after 2 of 4 shifts) -> on the same edge: sh_en=0, busy=0, res_valid=0, cmd_ready=1. A fresh command is then accepted normally.
- Clear, left, len=4, data=4'b1011 -> sh_din sequence 1,1,0,1; sh_q steps 0001, 0011, 0110, 1101. res_data=4'b1101, res_valid 7 edges after accept.
- Clear, right, len=4, data=4'b1011 -> sh_q steps 1000, 1100, 0110, 1011. res_data=4'b1011.
- No clear, left, len=2, data=2'b10, starting from sh_q=1011 -> no sh_clr pulse; sh_q steps 0110, 1101. res_data=4'b1101, res_valid 4 edges after accept.
- Backpressure and len clamp:
  - res_ready held low 5 cycles -> res_valid and res_data stable throughout, cmd_ready=0.
  - Release res_ready -> one-cycle handshake, then cmd_ready=1.
  - cmd_len=0 -> exactly 4 sh_en cycles.
- Abort during the third shift of len=4 -> sh_en=0 next edge, no res_valid, busy=0, sh_q holds its 3-bit partial value.
